fetch_stage: RTL and testbench

//  Instruction-fetch stage feeding the IF/ID register (if_id_reg, Reg A) of the 5-stage RISC-V pipe.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 12 +
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_stage_pkg;

  localparam int unsigned PC_W = 9;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 9'h000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] curr_pc;
    logic [31:0]     curr_instr;
  } if_id_reg_t;

  function automatic if_id_reg_t bubble(input logic [PC_W-1:0] pc);
    bubble.curr_pc    = pc;
    bubble.curr_instr = NOP_INSTR;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - one-outstanding request/response port to instruction memory
interface fetch_stage_if;

  logic                               imem_req;
  logic [fetch_stage_pkg::PC_W-1:0]   imem_addr;
  logic                               imem_rvalid;
  logic [31:0]                        imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);

endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, fetch FSM and hold buffer feeding the IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Stall,
  input  logic                Flush,
  input  logic [PC_W-1:0]     Redirect_Pc,
  fetch_stage_if.master       imem,
  output if_id_reg_t          IF_ID_o,
  output logic                IF_ID_valid
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  if_id_reg_t      if_id_q, if_id_d;
  logic            if_id_valid_q, if_id_valid_d;
  if_id_reg_t      hold_q, hold_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      if_id_q       <= bubble('0);
      if_id_valid_q <= 1'b0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_q       <= if_id_d;
      if_id_valid_q <= if_id_valid_d;
      hold_q        <= hold_d;
    end
  end

  // A redirect while a request is in flight must swallow the stale response via DROP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: state_d = Flush ? DROP : WAIT;
      WAIT: begin
        if (Flush)                 state_d = imem.imem_rvalid ? FETCH : DROP;
        else if (imem.imem_rvalid) state_d = Stall ? HOLD : FETCH;
      end
      HOLD: if (Flush || !Stall)   state_d = FETCH;
      DROP: if (imem.imem_rvalid)  state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    hold_d        = hold_q;
    if_id_d       = Stall ? if_id_q : bubble(pc_q);
    if_id_valid_d = Stall ? if_id_valid_q : 1'b0;
    if (Flush) begin
      pc_d          = Redirect_Pc & ~PC_W'(3);
      if_id_d       = bubble(pc_q);
      if_id_valid_d = 1'b0;
      hold_d        = '0;
    end else begin
      unique case (state_q)
        WAIT: begin
          if (imem.imem_rvalid) begin
            pc_d = pc_q + PC_W'(4);
            if (Stall) begin
              hold_d = '{curr_pc: pc_q, curr_instr: imem.imem_rdata};
            end else begin
              if_id_d       = '{curr_pc: pc_q, curr_instr: imem.imem_rdata};
              if_id_valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!Stall) begin
            if_id_d       = hold_q;
            if_id_valid_d = 1'b1;
            hold_d        = '0;
          end
        end
        FETCH, DROP: ;
      endcase
    end
  end

  always_comb begin
    imem.imem_req  = (state_q == FETCH) && !reset;
    imem.imem_addr = pc_q;
    IF_ID_o        = if_id_q;
    IF_ID_valid    = if_id_valid_q;
  end

  a_rvalid_expected: assert property (@(posedge clk) disable iff (reset)
    imem.imem_rvalid |-> (state_q == WAIT || state_q == DROP));

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall, flush;
  logic [8:0]      redirect_pc;
  if_id_reg_t      if_id;
  logic            if_id_valid;
  int              n_checks = 0;
  int              n_fail = 0;

  fetch_stage_if imem_bus ();

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .Stall       (stall),
    .Flush       (flush),
    .Redirect_Pc (redirect_pc),
    .imem        (imem_bus),
    .IF_ID_o     (if_id),
    .IF_ID_valid (if_id_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        fl;
    logic [8:0]  rpc;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [8:0]  e_addr;
    logic [40:0] e_ifid;
    logic        e_v;
  } vec_t;

  vec_t vec [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [8:0] addr,
                            input logic [40:0] ifid, input logic v);
    chk({tag, " imem_req"}, 64'(imem_bus.imem_req), 64'(req));
    chk({tag, " imem_addr"}, 64'(imem_bus.imem_addr), 64'(addr));
    chk({tag, " IF_ID_o"}, 64'(if_id), 64'(ifid));
    chk({tag, " IF_ID_valid"}, 64'(if_id_valid), 64'(v));
  endtask

  task automatic drive(input logic st, input logic fl, input logic [8:0] rpc,
                       input logic rv, input logic [31:0] rd);
    stall                = st;
    flush                = fl;
    redirect_pc          = rpc;
    imem_bus.imem_rvalid = rv;
    imem_bus.imem_rdata  = rd;
  endtask

  task automatic cycle(input string tag, input logic e_req, input logic [8:0] e_addr,
                       input logic [40:0] e_ifid, input logic e_v,
                       input logic st, input logic fl, input logic [8:0] rpc,
                       input logic rv, input logic [31:0] rd);
    #1;
    expect_out(tag, e_req, e_addr, e_ifid, e_v);
    drive(st, fl, rpc, rv, rd);
    @(negedge clk);
  endtask

  initial begin
    // Cycle-by-cycle: reset release, stall-into-HOLD, flush in WAIT with rvalid, flush in FETCH + slow imem.
    vec[0]  = '{0, 0, 9'h000, 0, 32'h0,        1, 9'h000, {9'h000, NOP_INSTR},     0};
    vec[1]  = '{0, 0, 9'h000, 1, 32'h00500093, 0, 9'h000, {9'h000, NOP_INSTR},     0};
    vec[2]  = '{0, 0, 9'h000, 0, 32'h0,        1, 9'h004, {9'h000, 32'h00500093}, 1};
    vec[3]  = '{0, 0, 9'h000, 1, 32'h00100113, 0, 9'h004, {9'h004, NOP_INSTR},     0};
    vec[4]  = '{0, 0, 9'h000, 0, 32'h0,        1, 9'h008, {9'h004, 32'h00100113}, 1};
    vec[5]  = '{1, 0, 9'h000, 1, 32'h002081b3, 0, 9'h008, {9'h008, NOP_INSTR},     0};
    vec[6]  = '{1, 0, 9'h000, 0, 32'h0,        0, 9'h00c, {9'h008, NOP_INSTR},     0};
    vec[7]  = '{0, 0, 9'h000, 0, 32'h0,        0, 9'h00c, {9'h008, NOP_INSTR},     0};
    vec[8]  = '{0, 0, 9'h000, 0, 32'h0,        1, 9'h00c, {9'h008, 32'h002081b3}, 1};
    vec[9]  = '{0, 1, 9'h040, 1, 32'hdeadbeef, 0, 9'h00c, {9'h00c, NOP_INSTR},     0};
    vec[10] = '{0, 1, 9'h043, 0, 32'h0,        1, 9'h040, {9'h00c, NOP_INSTR},     0};
    vec[11] = '{0, 0, 9'h000, 0, 32'h0,        0, 9'h040, {9'h040, NOP_INSTR},     0};
    vec[12] = '{0, 0, 9'h000, 0, 32'h0,        0, 9'h040, {9'h040, NOP_INSTR},     0};
    vec[13] = '{0, 0, 9'h000, 1, 32'hbadbad00, 0, 9'h040, {9'h040, NOP_INSTR},     0};
    vec[14] = '{0, 0, 9'h000, 0, 32'h0,        1, 9'h040, {9'h040, NOP_INSTR},     0};
    vec[15] = '{0, 0, 9'h000, 1, 32'h00310233, 0, 9'h040, {9'h040, NOP_INSTR},     0};
    vec[16] = '{0, 0, 9'h000, 0, 32'h0,        1, 9'h044, {9'h040, 32'h00310233}, 1};

    reset = 1'b1;
    drive(0, 0, 9'h000, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    expect_out("reset", 0, 9'h000, {9'h000, NOP_INSTR}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      cycle($sformatf("vec%0d", i + 1), vec[i].e_req, vec[i].e_addr, vec[i].e_ifid, vec[i].e_v,
            vec[i].st, vec[i].fl, vec[i].rpc, vec[i].rv, vec[i].rd);
    end

    // Flush and Stall together in HOLD
    cycle("hold_in",    0, 9'h044, {9'h044, NOP_INSTR}, 0,    1, 0, 9'h000, 1, 32'h11111111);
    cycle("hold_flush", 0, 9'h048, {9'h044, NOP_INSTR}, 0,    1, 1, 9'h080, 0, 32'h0);
    cycle("post_flush", 1, 9'h080, {9'h048, NOP_INSTR}, 0,    0, 0, 9'h000, 0, 32'h0);
    cycle("tgt_wait",   0, 9'h080, {9'h080, NOP_INSTR}, 0,    0, 0, 9'h000, 1, 32'h22222222);
    cycle("tgt_data",   1, 9'h084, {9'h080, 32'h22222222}, 1, 0, 1, 9'h1f8, 0, 32'h0);

    // PC wrap from 0x1F8, then asynchronous reset in WAIT
    cycle("wrap_drop",  0, 9'h1f8, {9'h084, NOP_INSTR}, 0,    0, 0, 9'h000, 1, 32'h0000dead);
    cycle("wrap_f0",    1, 9'h1f8, {9'h1f8, NOP_INSTR}, 0,    0, 0, 9'h000, 0, 32'h0);
    cycle("wrap_w0",    0, 9'h1f8, {9'h1f8, NOP_INSTR}, 0,    0, 0, 9'h000, 1, 32'haaaa0001);
    cycle("wrap_f1",    1, 9'h1fc, {9'h1f8, 32'haaaa0001}, 1, 0, 0, 9'h000, 0, 32'h0);
    cycle("wrap_w1",    0, 9'h1fc, {9'h1fc, NOP_INSTR}, 0,    0, 0, 9'h000, 1, 32'hbbbb0002);
    cycle("wrap_f2",    1, 9'h000, {9'h1fc, 32'hbbbb0002}, 1, 1, 0, 9'h000, 0, 32'h0);
    #1;
    expect_out("wait_pre_rst", 0, 9'h000, {9'h1fc, 32'hbbbb0002}, 1);
    #2;
    reset = 1'b1;
    #1;
    expect_out("async_rst", 0, 9'h000, {9'h000, NOP_INSTR}, 0);
    @(negedge clk);
    drive(0, 0, 9'h000, 0, 32'h0);
    reset = 1'b0;
    #1;
    expect_out("rst_release", 1, 9'h000, {9'h000, NOP_INSTR}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
